// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// FSM states, owner encoding and default bus widths.
package mem_port_arbiter_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin grant: on contention the side not served last wins.
// req[0] is the fetch side, req[1] the data side.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output owner_e     grant
);

  always_comb begin
    grant = OwnFetch;
    case (req)
      2'b01:   grant = OwnFetch;
      2'b10:   grant = OwnData;
      2'b11:   grant = (last_owner == OwnFetch) ? OwnData : OwnFetch;
      default: grant = OwnFetch;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access at a time,
// answering the served requester with a one-cycle ack and registered read data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            grant;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  rr_pick2 u_rr_pick2 (
    .req        ({dm_req_i, if_req_i}),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_req_i || dm_req_i) begin
          owner_d = grant;
          state_d = StAccess;
          if (grant == OwnData) begin
            addr_d  = dm_addr_i;
            wdata_d = dm_wdata_i;
            we_d    = dm_we_i;
          end else begin
            addr_d  = if_addr_i;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      StAccess: begin
        if (mem_ack_i) begin
          // Stores also refresh dm_rdata so its content stays deterministic.
          if (owner_q == OwnData) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            if_rdata_d = mem_rdata_i;
          end
          last_owner_d = owner_q;
          state_d      = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      last_owner_q <= OwnFetch;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output in the same cycle.
  assign mem_req_o   = (state_q == StAccess);
  assign mem_we_o    = (state_q == StAccess) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == StResp) && (owner_q == OwnFetch);
  assign dm_ack_o    = (state_q == StResp) && (owner_q == OwnData);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model
// and an ack scoreboard.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busy_o;

  mem_port_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_ack_o    (dm_ack_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          acks_seen = 0;
  int          lat = 1;
  bit          mem_auto = 1'b1;
  bit          force_ack = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Memory: acks in the lat-th cycle that mem_req_o is seen high.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clock);
      if (!mem_auto) begin
        mem_ack_i = force_ack;
        mem_rdata_i = 32'hFFFF_FFFF;
        cnt = 0;
      end else if (mem_req_o === 1'b1 && !mem_ack_i) begin
        cnt++;
        if (cnt == lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_read(mem_addr_o);
          if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
          cnt = 0;
        end
      end else begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end
    end
  end

  // Ack monitor: pops the scoreboard on every acknowledge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (if_ack_o === 1'b1 || dm_ack_o === 1'b1) begin
        acks_seen++;
        check("ack_exclusive", {31'b0, if_ack_o & dm_ack_o}, 32'd0);
        n_checks++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL unexpected_ack: observed if_ack=%b dm_ack=%b expected no ack",
                    if_ack_o, dm_ack_o);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ack_owner", {31'b0, dm_ack_o}, {31'b0, e.is_data});
          check("ack_rdata", e.is_data ? dm_rdata_o : if_rdata_o, e.rdata);
        end
      end
    end
  end

  initial begin
    int base;
    int cyc;
    int prev;
    int nacks;
    mem_model[32'h10] = 32'h0050_0093;
    reset = 1'b1;
    if_req_i = 1'b0;
    if_addr_i = '0;
    dm_req_i = 1'b0;
    dm_we_i = 1'b0;
    dm_addr_i = '0;
    dm_wdata_i = '0;
    tick();
    tick();
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_if_ack", {31'b0, if_ack_o}, 32'd0);
    check("rst_dm_ack", {31'b0, dm_ack_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch, 1-cycle memory.
    lat = 1;
    if_addr_i = 32'h10;
    if_req_i = 1'b1;
    sb.push_back('{1'b0, 32'h0050_0093});
    tick();
    check("f1_mem_req", {31'b0, mem_req_o}, 32'd1);
    check("f1_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("f1_mem_addr", mem_addr_o, 32'h10);
    check("f1_busy", {31'b0, busy_o}, 32'd1);
    tick();
    check("f1_if_ack", {31'b0, if_ack_o}, 32'd1);
    check("f1_if_rdata", if_rdata_o, 32'h0050_0093);
    check("f1_dm_ack", {31'b0, dm_ack_o}, 32'd0);
    if_req_i = 1'b0;
    tick();
    check("f1_idle", {31'b0, busy_o}, 32'd0);
    check("f1_ack_drop", {31'b0, if_ack_o}, 32'd0);

    // Store with four-cycle memory latency.
    lat = 4;
    dm_we_i = 1'b1;
    dm_addr_i = 32'h100;
    dm_wdata_i = 32'hDEAD_BEEF;
    dm_req_i = 1'b1;
    sb.push_back('{1'b1, mem_read(32'h100)});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_mem_req", {31'b0, mem_req_o}, 32'd1);
      check("st_mem_we", {31'b0, mem_we_o}, 32'd1);
      check("st_mem_addr", mem_addr_o, 32'h100);
      check("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      check("st_dm_ack_early", {31'b0, dm_ack_o}, 32'd0);
    end
    tick();
    check("st_dm_ack", {31'b0, dm_ack_o}, 32'd1);
    check("st_mem_req_drop", {31'b0, mem_req_o}, 32'd0);
    dm_req_i = 1'b0;
    dm_we_i = 1'b0;
    tick();
    check("st_ack_single", {31'b0, dm_ack_o}, 32'd0);
    check("st_idle", {31'b0, busy_o}, 32'd0);

    // Load whose inputs change while it is being served.
    lat = 3;
    dm_addr_i = 32'h40;
    dm_req_i = 1'b1;
    sb.push_back('{1'b1, mem_read(32'h40)});
    tick();
    check("gl_mem_addr", mem_addr_o, 32'h40);
    dm_addr_i = 32'h48;
    dm_we_i = 1'b1;
    dm_wdata_i = 32'h1111_1111;
    tick();
    check("gl_mem_addr_hold", mem_addr_o, 32'h40);
    check("gl_mem_we_hold", {31'b0, mem_we_o}, 32'd0);
    tick();
    check("gl_mem_addr_hold2", mem_addr_o, 32'h40);
    tick();
    check("gl_dm_ack", {31'b0, dm_ack_o}, 32'd1);
    dm_req_i = 1'b0;
    dm_we_i = 1'b0;
    tick();

    // Simultaneous requests out of reset: data, fetch, data, fetch.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 1;
    if_addr_i = 32'h20;
    dm_addr_i = 32'h80;
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, mem_read(32'h80)});
      sb.push_back('{1'b0, mem_read(32'h20)});
    end
    base = acks_seen;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acks_seen >= base + 4) break;
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    check("rr_ack_count", 32'(acks_seen), 32'(base + 4));
    tick();

    // Back-to-back fetches with a zero-wait memory.
    lat = 1;
    if_addr_i = 32'h30;
    if_req_i = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, mem_read(32'h30)});
    cyc = 0;
    prev = 0;
    nacks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cyc++;
      if (if_ack_o === 1'b1) begin
        if (nacks > 0) check("b2b_gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        nacks++;
        if (nacks == 3) begin
          if_req_i = 1'b0;
          break;
        end
      end
    end
    check("b2b_count", 32'(nacks), 32'd3);
    tick();

    // Reset mid-access, then a late memory ack.
    mem_auto = 1'b0;
    force_ack = 1'b0;
    if_addr_i = 32'h44;
    if_req_i = 1'b1;
    tick();
    check("rm_mem_req", {31'b0, mem_req_o}, 32'd1);
    tick();
    check("rm_mem_req_wait", {31'b0, mem_req_o}, 32'd1);
    reset = 1'b1;
    if_req_i = 1'b0;
    tick();
    check("rm_mem_req_drop", {31'b0, mem_req_o}, 32'd0);
    check("rm_busy", {31'b0, busy_o}, 32'd0);
    reset = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check("rm_late_busy", {31'b0, busy_o}, 32'd0);
    check("rm_late_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rm_late_if_rdata", if_rdata_o, 32'd0);
    tick();
    check("rm_no_if_ack", {31'b0, if_ack_o}, 32'd0);
    check("rm_no_dm_ack", {31'b0, dm_ack_o}, 32'd0);
    mem_auto = 1'b1;
    tick();

    // Normal service resumes after the abandoned access.
    if_req_i = 1'b1;
    sb.push_back('{1'b0, mem_read(32'h44)});
    tick();
    tick();
    check("rm_recover_ack", {31'b0, if_ack_o}, 32'd1);
    if_req_i = 1'b0;
    tick();
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one unified single-port memory between the core's instruction-fetch path and its load/store data path. It sits between the core and the memory, serialises accesses, and returns a one-cycle acknowledge with registered read data to the requester that was served. The core's multicycle sequencer stalls on the acknowledges. Arbitration is round-robin whenever both requesters are pending.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports (reset: synchronous, active-high; clock: clock):
- clock  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held high with if_addr_i stable until if_ack_o
- if_addr_i  in  ADDR_W  fetch address (the PC)
- if_ack_o  out  1  one-cycle pulse; if_rdata_o is valid in the same cycle
- if_rdata_o  out  DATA_W  fetched instruction, registered
- dm_req_i  in  1  data request; held high with dm_we_i, dm_addr_i, dm_wdata_i stable until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address (ALU result)
- dm_wdata_i  in  DATA_W  store data
- dm_ack_o  out  1  one-cycle pulse; dm_rdata_o is valid in the same cycle (loads)
- dm_rdata_o  out  DATA_W  load data, registered
- mem_req_o  out  1  memory request; held high until mem_ack_i
- mem_we_o  out  1  write enable toward memory
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_rdata_i  in  DATA_W  memory read data; valid when mem_ack_i=1
- mem_ack_i  in  1  memory completion; any latency of 1 or more cycles
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant that requester.
  - Both pending: grant the requester that was not served most recently (last_owner register).
  - On a grant: latch owner, address, wdata and we (forced to 0 for fetch) into registers, then go to ACCESS.
- ACCESS:
  - mem_req_o=1; mem_* outputs driven from the latched registers.
  - mem_ack_i=1: capture mem_rdata_i into the owner's rdata register, update last_owner, go to RESP.
  - mem_ack_i=0: stay in ACCESS.
- RESP: assert the owner's ack for exactly one cycle, then go to IDLE.
- Store: dm_rdata_o is still updated with mem_rdata_i. The value is don't-care, but it must be deterministic.
- Requester input changes while that requester is being served are ignored, because the arbiter works from the latched copies.
- A request seen high in IDLE on the cycle after its ack is a new transaction. Back-to-back requests from the same requester are legal.
- mem_ack_i outside ACCESS is ignored.
- Reset values:
  - State IDLE.
  - All acks 0, mem_req_o 0, mem_we_o 0, busy_o 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o all 0.
  - last_owner = FETCH, so data wins the first simultaneous request.
- Reset mid-transaction: abandon the access, drop mem_req_o the next cycle, issue no ack. A late mem_ack_i is ignored.

## Timing
- Request high in IDLE at cycle 0 gives mem_req_o=1 from cycle 1.
- mem_ack_i at cycle k≥1 gives the ack pulse at cycle k+1 and IDLE at cycle k+2.
- Minimum turnaround is 3 cycles per access; throughput is one access per 3 cycles with a zero-wait memory.
- if_ack_o and dm_ack_o are never high in the same cycle.
- At most one mem_req_o transaction is outstanding at any time.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package:
  - State enum {IDLE, ACCESS, RESP}.
  - Owner encoding {OWN_FETCH=0, OWN_DATA=1}.
  - Default ADDR_W and DATA_W values.
- One small sub-module, rr_pick2: a combinational two-way round-robin grant. Inputs are req[1:0] and last_owner; output is the grant owner. It is reusable for future peripheral-bus sharing.
- Everything else is a single FSM block plus the latch registers.

## Test plan
- Single fetch:
  - Stimulus: if_req_i=1, if_addr_i=0x0000_0010, memory returns 0x0050_0093 with 1-cycle latency.
  - Required response: mem_req_o=1 in cycle 1, mem_we_o=0; if_ack_o pulse in cycle 2 with if_rdata_o=0x0050_0093; dm_ack_o stays 0.
- Store with wait states:
  - Stimulus: dm_req_i=1, dm_we_i=1, dm_addr_i=0x100, dm_wdata_i=0xDEAD_BEEF, mem_ack_i delayed 4 cycles.
  - Required response: mem_req_o held for 4 cycles with stable addr, data and we; a single dm_ack_o pulse one cycle after mem_ack_i.
- Simultaneous requests:
  - Stimulus: if_req_i and dm_req_i both high out of reset, both held.
  - Required response: data served first, then fetch, then data again, alternating.
- Back-to-back fetch:
  - Stimulus: if_req_i held high across the ack.
  - Required response: a new access starts in the cycle after the RESP cycle; exactly 3 cycles between acks with a zero-wait memory.
- Reset mid-access:
  - Stimulus: assert reset while in ACCESS; pulse mem_ack_i after reset is released.
  - Required response: mem_req_o goes to 0, no ack is issued, state returns to IDLE, and the late mem_ack_i has no effect.
- Input glitch during service:
  - Stimulus: change dm_addr_i while in ACCESS.
  - Required response: mem_addr_o keeps the latched value.
